// File: rtl/vdp_sprite_eval_if.sv
// VRAM read port shared by the sprite evaluator (master) and the gfx fetch/VRAM side.
interface vdp_sprite_eval_if;
    logic [12:0] vaddr;
    logic [15:0] vdata;
    logic        busy;

    modport master (output vaddr, output busy, input vdata);
    modport slave  (input vaddr, input busy, output vdata);
endinterface

// File: rtl/vdp_sprite_eval.sv
// Per-line sprite evaluation: scans the attribute table for the first MAX_SPR sprites
// covering a line, then fetches their X/pattern bytes into a small list for gfx.

module vdp_sprite_eval_lane #(
    parameter logic [7:0] Y_TERM = 8'hD0
) (
    input  logic [7:0] y,
    input  logic [7:0] line,
    input  logic       h16,
    input  logic       mag,
    output logic       term,
    output logic       vis,
    output logic [3:0] row
);
    logic [7:0] d;
    logic [8:0] h;

    // Y is the line above the sprite's first row, hence the extra -1; wraps mod 256.
    always_comb begin
        d    = line - y - 8'd1;
        h    = (h16 ? 9'd16 : 9'd8) << mag;
        term = (y == Y_TERM);
        vis  = ({1'b0, d} < h);
        row  = mag ? d[4:1] : d[3:0];
    end
endmodule

module vdp_sprite_eval #(
    parameter int         MAX_SPR = 8,
    parameter int         NUM_SPR = 64,
    parameter logic [7:0] Y_TERM  = 8'hD0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               line,
    input  logic [5:0]               base_sprattr,
    input  logic                     spr_h16,
    input  logic                     spr_mag,
    vdp_sprite_eval_if.master        vram,
    output logic                     done,
    output logic [3:0]               spr_count,
    output logic                     spr_overflow,
    input  logic [2:0]               rd_idx,
    output logic [7:0]               rd_x,
    output logic [7:0]               rd_pattern,
    output logic [3:0]               rd_row
);
    localparam int LANES     = 2;
    localparam int NUM_WORDS = NUM_SPR / LANES;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH, S_DONE} state_t;

    typedef struct packed {
        logic [5:0] idx;
        logic [3:0] row;
        logic [7:0] x;
        logic [7:0] pat;
    } spr_ent_t;

    state_t     state_q, state_d;
    logic [7:0] line_q;
    logic [5:0] base_q;
    logic       h16_q, mag_q;
    logic [3:0] count_q, cnt_nx;
    logic       ovf_q, ovf_hit, stop;
    logic [5:0] word_k;
    logic [3:0] fi_q;
    logic       rd_vld;
    logic [4:0] rd_tag;
    logic       issue_scan, issue_fetch;
    spr_ent_t   ents [MAX_SPR];

    logic [LANES-1:0][7:0] y_byte;
    logic [LANES-1:0]      term, vis;
    logic [LANES-1:0][3:0] row;
    logic [LANES-1:0]      app_en;
    logic [LANES-1:0][2:0] app_slot;

    // Lane 0 is the even (low) byte, so it is evaluated first.
    assign y_byte = vram.vdata;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vdp_sprite_eval_lane #(.Y_TERM(Y_TERM)) u_lane (
            .y    (y_byte[l]),
            .line (line_q),
            .h16  (h16_q),
            .mag  (mag_q),
            .term (term[l]),
            .vis  (vis[l]),
            .row  (row[l])
        );
    end

    // Walk both lanes in order with a running count so two hits can land in one cycle.
    always_comb begin
        cnt_nx   = count_q;
        ovf_hit  = 1'b0;
        stop     = 1'b0;
        app_en   = '0;
        app_slot = '0;
        if (state_q == S_SCAN && rd_vld) begin
            for (int l = 0; l < LANES; l++) begin
                if (!stop) begin
                    if (term[l]) begin
                        stop = 1'b1;
                    end else if (vis[l]) begin
                        if (cnt_nx == 4'(MAX_SPR)) begin
                            ovf_hit = 1'b1;
                            stop    = 1'b1;
                        end else begin
                            app_en[l]   = 1'b1;
                            app_slot[l] = cnt_nx[2:0];
                            cnt_nx      = cnt_nx + 4'd1;
                        end
                    end
                end
            end
            if (rd_tag == 5'(NUM_WORDS - 1)) stop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_SCAN;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_SCAN:  if (stop) state_d = (cnt_nx == 4'd0) ? S_DONE : S_FETCH;
                S_FETCH: if (fi_q == count_q) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        vram.busy    = (state_q == S_SCAN) || (state_q == S_FETCH);
        done         = (state_q == S_DONE);
        spr_overflow = (state_q == S_DONE) && ovf_q;
        issue_scan   = (state_q == S_SCAN) && (word_k < 6'(NUM_WORDS));
        issue_fetch  = (state_q == S_FETCH) && (fi_q < count_q);
        vram.vaddr   = '0;
        if (issue_scan)       vram.vaddr = {base_q, 2'b00, word_k[4:0]};
        else if (issue_fetch) vram.vaddr = {base_q, 1'b1, ents[fi_q[2:0]].idx};
    end

    // Ending the scan drops whatever read is still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q  <= '0;
            base_q  <= '0;
            h16_q   <= 1'b0;
            mag_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            word_k  <= '0;
            fi_q    <= '0;
            rd_vld  <= 1'b0;
            rd_tag  <= '0;
        end else if (start) begin
            line_q  <= line;
            base_q  <= base_sprattr;
            h16_q   <= spr_h16;
            mag_q   <= spr_mag;
            count_q <= '0;
            ovf_q   <= 1'b0;
            word_k  <= '0;
            fi_q    <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= issue_scan || issue_fetch;
            rd_tag <= issue_fetch ? {2'b00, fi_q[2:0]} : word_k[4:0];
            if (issue_scan)  word_k <= word_k + 6'd1;
            if (issue_fetch) fi_q   <= fi_q + 4'd1;
            if (state_q == S_SCAN && rd_vld) begin
                count_q <= cnt_nx;
                if (ovf_hit) ovf_q  <= 1'b1;
                if (stop)    rd_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !start) begin
            for (int l = 0; l < LANES; l++) begin
                if (app_en[l]) begin
                    ents[app_slot[l]].idx <= {rd_tag, 1'(l)};
                    ents[app_slot[l]].row <= row[l];
                end
            end
            if (state_q == S_FETCH && rd_vld) begin
                ents[rd_tag[2:0]].x   <= vram.vdata[7:0];
                ents[rd_tag[2:0]].pat <= vram.vdata[15:8];
            end
        end
    end

    assign spr_count  = count_q;
    assign rd_x       = ents[rd_idx].x;
    assign rd_pattern = ents[rd_idx].pat & ~{7'd0, h16_q};
    assign rd_row     = ents[rd_idx].row;
endmodule

// File: tb/tb_vdp_sprite_eval.sv
// Directed bench for vdp_sprite_eval with a 1-cycle-latency VRAM model.
module tb_vdp_sprite_eval;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] line;
    logic [5:0] base_sprattr;
    logic       spr_h16, spr_mag;
    logic       done, spr_overflow;
    logic [3:0] spr_count, rd_row;
    logic [2:0] rd_idx;
    logic [7:0] rd_x, rd_pattern;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:8191];
    logic [12:0] first_vaddr;
    int          pass_cycles;
    bit          got_done;
    logic        got_ovf;

    vdp_sprite_eval_if vif();

    vdp_sprite_eval dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .line         (line),
        .base_sprattr (base_sprattr),
        .spr_h16      (spr_h16),
        .spr_mag      (spr_mag),
        .vram         (vif),
        .done         (done),
        .spr_count    (spr_count),
        .spr_overflow (spr_overflow),
        .rd_idx       (rd_idx),
        .rd_x         (rd_x),
        .rd_pattern   (rd_pattern),
        .rd_row       (rd_row)
    );

    always #5 clk = ~clk;
    always @(posedge clk) vif.vdata <= mem[vif.vaddr];

    task automatic set_y(input int n, input logic [7:0] y);
        logic [12:0] a;
        a = {base_sprattr, 2'b00, 5'(n >> 1)};
        if (n % 2 == 0) mem[a][7:0] = y;
        else            mem[a][15:8] = y;
    endtask

    task automatic set_xp(input int n, input logic [7:0] x, input logic [7:0] p);
        mem[{base_sprattr, 1'b1, 6'(n)}] = {p, x};
    endtask

    task automatic clear_table();
        for (int n = 0; n < 64; n++) begin
            set_y(n, 8'hD0);
            set_xp(n, 8'h00, 8'h00);
        end
    endtask

    task automatic run_pass(input logic [7:0] ln, input logic h16, input logic mag);
        @(negedge clk);
        line = ln; spr_h16 = h16; spr_mag = mag; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_vaddr = vif.vaddr;
        got_done = 0; got_ovf = 1'b0; pass_cycles = -1;
        for (int c = 0; c < 60 && !got_done; c++) begin
            if (done) begin
                got_done = 1; got_ovf = spr_overflow; pass_cycles = c;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; line = 8'd0; base_sprattr = 6'h3F;
        spr_h16 = 1'b0; spr_mag = 1'b0; rd_idx = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", vif.busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (spr_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", spr_overflow); end
        checks++; if (spr_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", spr_count); end
        checks++; if (vif.vaddr !== 13'd0) begin errors++; $display("FAIL reset_vaddr: got %h want 0", vif.vaddr); end
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL reset_wins_start: busy %b want 0", vif.busy); end
    endtask

    task automatic test_empty();
        base_sprattr = 6'h3F; clear_table();
        run_pass(8'd10, 1'b0, 1'b0);
        checks++; if (first_vaddr !== 13'h1F80) begin errors++; $display("FAIL empty_vaddr0: got %h want 1f80", first_vaddr); end
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL empty_done: got %0b want 1", got_done); end
        checks++; if (pass_cycles < 0 || pass_cycles > 3) begin errors++; $display("FAIL empty_latency: got %0d want <=3", pass_cycles); end
        checks++; if (spr_count !== 4'd0) begin errors++; $display("FAIL empty_count: got %0d want 0", spr_count); end
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL empty_ovf: got %b want 0", got_ovf); end
    endtask

    task automatic test_single();
        base_sprattr = 6'h3F; clear_table();
        set_y(0, 8'd9); set_xp(0, 8'h40, 8'h21);
        run_pass(8'd10, 1'b0, 1'b0);
        rd_idx = 3'd0; #1;
        checks++; if (spr_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d want 1", spr_count); end
        checks++; if (rd_x !== 8'h40) begin errors++; $display("FAIL single_x: got %h want 40", rd_x); end
        checks++; if (rd_pattern !== 8'h21) begin errors++; $display("FAIL single_pat: got %h want 21", rd_pattern); end
        checks++; if (rd_row !== 4'd0) begin errors++; $display("FAIL single_row: got %0d want 0", rd_row); end
        run_pass(8'd10, 1'b1, 1'b0);
        #1;
        checks++; if (rd_pattern !== 8'h20) begin errors++; $display("FAIL h16_pat: got %h want 20", rd_pattern); end
        run_pass(8'd25, 1'b1, 1'b1);
        #1;
        checks++; if (spr_count !== 4'd1) begin errors++; $display("FAIL mag_count: got %0d want 1", spr_count); end
        checks++; if (rd_row !== 4'd7) begin errors++; $display("FAIL mag_row: got %0d want 7", rd_row); end
    endtask

    task automatic test_overflow();
        base_sprattr = 6'h3F; clear_table();
        for (int n = 0; n < 10; n++) begin set_y(n, 8'd9); set_xp(n, 8'(8'h10 + n), 8'(8'h80 + n)); end
        run_pass(8'd12, 1'b0, 1'b0);
        checks++; if (spr_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", spr_count); end
        checks++; if (got_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", got_ovf); end
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i); #1;
            checks++; if (rd_x !== 8'(8'h10 + i) || rd_pattern !== 8'(8'h80 + i) || rd_row !== 4'd2) begin
                errors++; $display("FAIL ovf_entry%0d: got x=%h p=%h r=%0d want x=%h p=%h r=2", i, rd_x, rd_pattern, rd_row, 8'(8'h10 + i), 8'(8'h80 + i));
            end
        end
        // Sprite 0 hidden: word 4 carries the 8th and 9th hits together.
        set_y(0, 8'h80);
        run_pass(8'd12, 1'b0, 1'b0);
        checks++; if (spr_count !== 4'd8 || got_ovf !== 1'b1) begin errors++; $display("FAIL pair_ovf: got count=%0d ovf=%b want 8/1", spr_count, got_ovf); end
        rd_idx = 3'd0; #1;
        checks++; if (rd_x !== 8'h11) begin errors++; $display("FAIL pair_first: got %h want 11", rd_x); end
        rd_idx = 3'd7; #1;
        checks++; if (rd_x !== 8'h18) begin errors++; $display("FAIL pair_last: got %h want 18", rd_x); end
        clear_table();
        for (int n = 0; n < 8; n++) set_y(n, 8'd9);
        run_pass(8'd12, 1'b0, 1'b0);
        checks++; if (spr_count !== 4'd8 || got_ovf !== 1'b0) begin errors++; $display("FAIL exact8: got count=%0d ovf=%b want 8/0", spr_count, got_ovf); end
    endtask

    task automatic test_wrap();
        base_sprattr = 6'h3F; clear_table();
        set_y(0, 8'hF8); set_xp(0, 8'h05, 8'h06);
        run_pass(8'd2, 1'b1, 1'b0);
        rd_idx = 3'd0; #1;
        checks++; if (spr_count !== 4'd1) begin errors++; $display("FAIL wrap16_count: got %0d want 1", spr_count); end
        checks++; if (rd_row !== 4'd9) begin errors++; $display("FAIL wrap16_row: got %0d want 9", rd_row); end
        run_pass(8'd2, 1'b0, 1'b0);
        checks++; if (spr_count !== 4'd0) begin errors++; $display("FAIL wrap8_count: got %0d want 0", spr_count); end
    endtask

    task automatic test_term();
        base_sprattr = 6'h12; clear_table();
        set_y(0, 8'd9); set_xp(0, 8'h33, 8'h44);
        set_y(1, 8'h80); set_y(2, 8'h80); set_y(3, 8'hD0); set_y(4, 8'd9);
        run_pass(8'd10, 1'b0, 1'b0);
        rd_idx = 3'd0; #1;
        checks++; if (first_vaddr !== 13'h0900) begin errors++; $display("FAIL term_vaddr0: got %h want 0900", first_vaddr); end
        checks++; if (spr_count !== 4'd1) begin errors++; $display("FAIL term_odd_count: got %0d want 1", spr_count); end
        checks++; if (rd_x !== 8'h33) begin errors++; $display("FAIL term_odd_x: got %h want 33", rd_x); end
        set_y(2, 8'hD0); set_y(3, 8'd9);
        run_pass(8'd10, 1'b0, 1'b0);
        checks++; if (spr_count !== 4'd1) begin errors++; $display("FAIL term_even_count: got %0d want 1", spr_count); end
    endtask

    task automatic test_back_to_back();
        int ndone, first;
        base_sprattr = 6'h3F; clear_table();
        for (int n = 0; n < 64; n++) set_y(n, 8'h80);
        set_y(0, 8'd9);  set_xp(0, 8'h40, 8'h11);
        set_y(5, 8'd99); set_xp(5, 8'h77, 8'h55);
        ndone = 0; first = -1;
        @(negedge clk); line = 8'd10; spr_h16 = 1'b0; spr_mag = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) begin if (done) ndone++; @(negedge clk); end
        line = 8'd100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (done) begin ndone++; if (first < 0) first = c; end
            @(negedge clk);
        end
        rd_idx = 3'd0; #1;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_dones: got %0d want 1", ndone); end
        checks++; if (first < 0 || first > 43) begin errors++; $display("FAIL restart_latency: got %0d want <=43", first); end
        checks++; if (spr_count !== 4'd1 || rd_x !== 8'h77) begin errors++; $display("FAIL restart_list: got count=%0d x=%h want 1/77", spr_count, rd_x); end
    endtask

    task automatic test_reset_fetch();
        bit found;
        int nd;
        base_sprattr = 6'h3F; clear_table();
        for (int n = 0; n < 8; n++) set_y(n, 8'd9);
        @(negedge clk); line = 8'd12; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (vif.busy && vif.vaddr[6]) found = 1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL fetch_reached: got 0 want 1"); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (vif.busy !== 1'b0 || spr_count !== 4'd0 || done !== 1'b0) begin
            errors++; $display("FAIL fetch_reset: got busy=%b count=%0d done=%b want 0/0/0", vif.busy, spr_count, done);
        end
        reset = 1'b0; nd = 0;
        repeat (50) begin @(negedge clk); if (done) nd++; end
        checks++; if (nd !== 0) begin errors++; $display("FAIL fetch_reset_nodone: got %0d want 0", nd); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_overflow();
        test_wrap();
        test_term();
        test_back_to_back();
        test_reset_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
